// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared state/status types and bus widths for the Wishbone master engine
package wb_master_pkg;
  localparam int ADR_W = 64;
  localparam int DAT_W = 64;
  localparam int SEL_W = 8;
  typedef enum logic [1:0] {IDLE, BUS, RETRY, RESP} state_t;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_ERR = 2'b01, ST_RTY = 2'b10, ST_TMO = 2'b11} status_t;
endpackage

// File: rtl/wb_master_timeout.sv
// wb_master_timeout: counts unterminated bus cycles and flags the last one allowed
module wb_master_timeout #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [15:0] r_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (en) r_cnt <= r_cnt + 16'd1;
  assign expired = r_cnt == 16'(TIMEOUT - 1);
endmodule

// File: rtl/wb_master_engine.sv
// wb_master_engine: single-outstanding Wishbone master with retry and timeout handling
module wb_master_engine
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT   = 256,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [DAT_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic [1:0]       rsp_status,
  output logic             CYC_O,
  output logic             STB_O,
  output logic             WE_O,
  output logic [ADR_W-1:0] ADR_O,
  output logic [DAT_W-1:0] DAT_O,
  output logic [SEL_W-1:0] SEL_O,
  input  logic [DAT_W-1:0] DAT_I,
  input  logic             ACK_I,
  input  logic             ERR_I,
  input  logic             RTY_I
);
  state_t           r_state, w_nxt;
  status_t          r_status, w_status;
  logic             r_live, r_we;
  logic [ADR_W-1:0] r_adr;
  logic [DAT_W-1:0] r_dat, r_rdat, w_rdat;
  logic [SEL_W-1:0] r_sel;
  logic [15:0]      r_retry, w_retry;
  logic             w_accept, w_bus, w_hold, w_term, w_expired;
  assign w_accept = cmd_valid && cmd_ready;
  assign w_bus    = r_state == BUS;
  assign w_hold   = w_bus || r_state == RETRY;
  assign w_term   = ACK_I || ERR_I || RTY_I;
  // Counter idles at zero outside BUS, so every BUS entry starts a fresh wait window
  wb_master_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (!w_bus),
    .en      (w_bus && !w_term),
    .expired (w_expired)
  );
  always_comb begin
    w_nxt    = r_state;
    w_status = r_status;
    w_rdat   = r_rdat;
    w_retry  = r_retry;
    case (r_state)
      IDLE: if (w_accept) begin
        w_nxt   = BUS;
        w_retry = '0;
      end
      BUS: if (ERR_I) begin
        w_nxt    = RESP;
        w_status = ST_ERR;
        w_rdat   = '0;
      end else if (RTY_I && r_retry < 16'(MAX_RETRY)) begin
        w_nxt   = RETRY;
        w_retry = r_retry + 16'd1;
      end else if (RTY_I) begin
        w_nxt    = RESP;
        w_status = ST_RTY;
        w_rdat   = '0;
      end else if (ACK_I) begin
        w_nxt    = RESP;
        w_status = ST_OK;
        w_rdat   = r_we ? '0 : DAT_I;
      end else if (w_expired) begin
        w_nxt    = RESP;
        w_status = ST_TMO;
        w_rdat   = '0;
      end
      RETRY: w_nxt = BUS;
      RESP: if (rsp_ready) begin
        w_nxt   = IDLE;
        w_retry = '0;
      end
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state  <= IDLE;
      r_status <= ST_OK;
      r_live   <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_sel    <= '0;
      r_rdat   <= '0;
      r_retry  <= '0;
    end else begin
      r_state  <= w_nxt;
      r_status <= w_status;
      r_live   <= 1'b1;
      r_rdat   <= w_rdat;
      r_retry  <= w_retry;
      if (w_accept) begin
        r_we  <= cmd_we;
        r_adr <= cmd_adr;
        r_dat <= cmd_dat;
        r_sel <= cmd_sel;
      end
    end
  assign cmd_ready  = r_live && r_state == IDLE;
  assign CYC_O      = w_bus;
  assign STB_O      = w_bus;
  assign WE_O       = w_hold && r_we;
  assign ADR_O      = w_hold ? r_adr : '0;
  assign DAT_O      = w_hold ? r_dat : '0;
  assign SEL_O      = w_hold ? r_sel : '0;
  assign rsp_valid  = r_state == RESP;
  assign rsp_dat    = rsp_valid ? r_rdat : '0;
  assign rsp_status = rsp_valid ? r_status : ST_OK;
endmodule

// File: tb/tb_wb_master_engine.sv
// tb_wb_master_engine: scenario tasks plus randomized transfers against a termination-plan model
module tb_wb_master_engine;
  localparam int TMO = 8;
  localparam int MR  = 3;
  logic        clk = 0, rst = 0;
  logic        cmd_valid = 0, cmd_we = 0, rsp_ready = 0;
  logic [63:0] cmd_adr = 0, cmd_dat = 0, DAT_I = 0;
  logic [7:0]  cmd_sel = 0;
  logic        ACK_I = 0, ERR_I = 0, RTY_I = 0;
  logic        cmd_ready, rsp_valid, CYC_O, STB_O, WE_O;
  logic [63:0] rsp_dat, ADR_O, DAT_O;
  logic [1:0]  rsp_status;
  logic [7:0]  SEL_O;
  int checks = 0, failures = 0;
  logic [2:0]  p_t[5];
  int          p_c[5];
  logic [63:0] p_d[5];

  always #5 clk = ~clk;

  wb_master_engine #(.TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status), .CYC_O(CYC_O),
    .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I)
  );

  // Plan per attempt: p_t = {err,rty,ack} raised on strobe cycle p_c; p_c > TMO means the slave stays silent
  task automatic model(input logic we, output logic [1:0] st, output logic [63:0] d,
                       output int stb, output int att);
    int r;
    bit done;
    r = 0; done = 0; st = 2'b11; d = '0; stb = 0; att = 0;
    for (int a = 0; a < 5; a++) if (!done) begin
      att = a + 1;
      if (p_c[a] > TMO) begin
        stb += TMO; st = 2'b11; done = 1;
      end else begin
        stb += p_c[a];
        if (p_t[a][2]) begin st = 2'b01; done = 1; end
        else if (p_t[a][1]) begin
          if (r < MR) r++;
          else begin st = 2'b10; done = 1; end
        end else begin st = 2'b00; d = we ? 64'd0 : p_d[a]; done = 1; end
      end
    end
  endtask

  task automatic run_txn(input string nm, input logic we, input logic [63:0] adr,
                         input logic [63:0] dat, input logic [7:0] sel, input int hold);
    logic [1:0]  est;
    logic [63:0] ed;
    int estb, eatt, stb, att, k, gap, bad_field, bad_gap, bad_hold, n;
    bit got;
    model(we, est, ed, estb, eatt);
    stb = 0; att = 0; k = 0; gap = 0; bad_field = 0; bad_gap = 0; bad_hold = 0; got = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL %s_ready got=%b exp=1", nm, cmd_ready); end
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      cmd_valid = 0; cmd_we = ~we; cmd_adr = {$urandom, $urandom}; cmd_dat = {$urandom, $urandom};
      cmd_sel = 8'($urandom);
      {ERR_I, RTY_I, ACK_I} = 3'b000;
      DAT_I = {$urandom, $urandom};
      if (rsp_valid) got = 1;
      else if (CYC_O) begin
        if (k == 0) begin
          if (att > 0 && gap != 1) bad_gap++;
          att++;
        end
        gap = 0; k++; stb++;
        if (STB_O !== 1'b1 || WE_O !== we || ADR_O !== adr || DAT_O !== dat || SEL_O !== sel) bad_field++;
        if (att >= 1 && att <= 5 && k == p_c[att-1]) begin
          {ERR_I, RTY_I, ACK_I} = p_t[att-1];
          DAT_I = p_d[att-1];
        end
      end else begin
        if (att > 0) begin gap++; k = 0; end
        if (WE_O !== we || ADR_O !== adr || DAT_O !== dat || SEL_O !== sel) bad_field++;
        {ERR_I, RTY_I, ACK_I} = 3'($urandom);
      end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL %s_rsp_timeout got=0 exp=1", nm); end
    checks++;
    if (rsp_status !== est) begin failures++; $display("FAIL %s_status got=%b exp=%b", nm, rsp_status, est); end
    checks++;
    if (rsp_dat !== ed) begin failures++; $display("FAIL %s_dat got=%h exp=%h", nm, rsp_dat, ed); end
    checks++;
    if (CYC_O !== 1'b0) begin failures++; $display("FAIL %s_cyc_after got=%b exp=0", nm, CYC_O); end
    checks++;
    if (stb !== estb) begin failures++; $display("FAIL %s_stb_cycles got=%0d exp=%0d", nm, stb, estb); end
    checks++;
    if (att !== eatt) begin failures++; $display("FAIL %s_attempts got=%0d exp=%0d", nm, att, eatt); end
    checks++;
    if (bad_field != 0 || bad_gap != 0) begin
      failures++; $display("FAIL %s_bus_fields got=%0d/%0d exp=0/0", nm, bad_field, bad_gap);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      {ERR_I, RTY_I, ACK_I} = 3'($urandom);
      DAT_I = {$urandom, $urandom};
      if (rsp_valid !== 1'b1 || rsp_status !== est || rsp_dat !== ed || cmd_ready !== 1'b0) bad_hold++;
    end
    checks++;
    if (bad_hold != 0) begin failures++; $display("FAIL %s_hold got=%0d exp=0", nm, bad_hold); end
    @(negedge clk);
    {ERR_I, RTY_I, ACK_I} = 3'b000;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || CYC_O !== 1'b0 || ADR_O !== 64'd0) begin
      failures++;
      $display("FAIL %s_release got=v%b r%b c%b a%h exp=v0 r1 c0 a0", nm, rsp_valid, cmd_ready, CYC_O, ADR_O);
    end
  endtask

  task automatic single(input logic [2:0] t, input int c, input logic [63:0] d);
    for (int a = 0; a < 5; a++) begin p_t[a] = 3'b001; p_c[a] = 1; p_d[a] = 64'd0; end
    p_t[0] = t; p_c[0] = c; p_d[0] = d;
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 0 || rsp_valid !== 0 || CYC_O !== 0 || STB_O !== 0 || ADR_O !== 0 || rsp_status !== 0) begin
      failures++; $display("FAIL reset_outputs got=r%b v%b c%b exp=0", cmd_ready, rsp_valid, CYC_O);
    end
    rst = 1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_early got=%b exp=0", cmd_ready); end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_rise got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_read_ack;
    single(3'b001, 2, 64'hDEADBEEF_CAFEF00D);
    run_txn("read_ack", 1'b0, 64'h100, 64'h1234, 8'hFF, 0);
  endtask

  task automatic test_write_err;
    single(3'b100, 3, 64'hFFFF_FFFF_FFFF_FFFF);
    run_txn("write_err", 1'b1, 64'h2000, 64'h55, 8'h01, 1);
  endtask

  task automatic test_retry;
    for (int a = 0; a < 5; a++) begin p_t[a] = 3'b010; p_c[a] = 1; p_d[a] = 64'hAB; end
    run_txn("retry_exhaust", 1'b0, 64'h300, 64'h0, 8'h0F, 0);
    p_t[2] = 3'b001; p_c[2] = 2; p_d[2] = 64'h0123_4567_89AB_CDEF;
    run_txn("retry_ack3", 1'b0, 64'h308, 64'h0, 8'hF0, 0);
  endtask

  task automatic test_timeout;
    single(3'b001, TMO + 1, 64'h1);
    run_txn("timeout", 1'b0, 64'h400, 64'h0, 8'hFF, 0);
    single(3'b001, TMO, 64'h7777);
    run_txn("ack_last", 1'b0, 64'h408, 64'h0, 8'hFF, 0);
  endtask

  task automatic test_err_ack;
    single(3'b101, 1, 64'h9999);
    run_txn("err_ack", 1'b0, 64'h500, 64'h0, 8'h3C, 0);
  endtask

  task automatic test_hold;
    single(3'b001, 1, 64'hFACE);
    run_txn("hold5", 1'b0, 64'h600, 64'h0, 8'hFF, 5);
  endtask

  task automatic test_reset_midbus;
    int n;
    @(negedge clk);
    cmd_valid = 1; cmd_we = 1; cmd_adr = 64'h700; cmd_dat = 64'h11; cmd_sel = 8'hFF;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    checks++;
    if (CYC_O !== 1'b1) begin failures++; $display("FAIL midbus_cyc got=%b exp=1", CYC_O); end
    #2 rst = 0;
    #1;
    checks++;
    if (CYC_O !== 0 || STB_O !== 0 || rsp_valid !== 0 || cmd_ready !== 0 || WE_O !== 0) begin
      failures++; $display("FAIL midbus_async got=c%b s%b v%b r%b exp=0", CYC_O, STB_O, rsp_valid, cmd_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || CYC_O !== 1'b0) begin
      failures++; $display("FAIL midbus_release got=r%b v%b c%b exp=r1 v0 c0", cmd_ready, rsp_valid, CYC_O);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      for (int a = 0; a < 5; a++) begin
        p_t[a] = 3'($urandom_range(1, 7));
        p_c[a] = $urandom_range(1, TMO + 2);
        p_d[a] = {$urandom, $urandom};
      end
      run_txn("random", 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
              $urandom_range(0, 4));
    end
  endtask

  initial begin
    test_reset;
    test_read_ack;
    test_write_err;
    test_retry;
    test_timeout;
    test_err_ack;
    test_hold;
    test_reset_midbus;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
